// File: rtl/uart_pkg.sv
// Types and helpers shared between the UART transmit and receive blocks.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a falling-edge start detector.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic start_edge
);

  logic rxd_m;
  logic rxd_p;

  // Idle-high reset so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  assign start_edge = rxd_p & ~rxd_s;

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: start, 8 data bits LSB first, optional even parity, one stop bit.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       par_EN,
  output logic [7:0] RX_DATA,
  output logic       data_valid,
  output logic       par_err,
  output logic       stop_err,
  output logic       busy
);

  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic rxd_s;
  logic start_edge;

  uart_rx_sync u_sync (
    .clk        (CLK),
    .rst_n      (RST),
    .rxd        (RXD),
    .rxd_s      (rxd_s),
    .start_edge (start_edge)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bad_q, par_bad_d;
  logic                 valid_q, valid_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 busy_q, busy_d;
  logic                 sample;

  assign sample = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    par_en_d   = par_en_q;
    par_bad_d  = par_bad_q;
    valid_d    = 1'b0;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    busy_d     = busy_q;

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          par_en_d  = par_EN;
          par_bad_d = 1'b0;
          busy_d    = 1'b1;
          bit_idx_d = 3'd0;
          // With HALF = 0 the detection edge already is the mid-bit start sample.
          if (HALF == 0) begin
            state_d   = StData;
            clk_cnt_d = '0;
          end else begin
            state_d   = StStart;
            clk_cnt_d = CNT_W'(1);
          end
        end
      end
      StStart: begin
        if (clk_cnt_q == CNT_W'(HALF)) begin
          clk_cnt_d = '0;
          if (!rxd_s) begin
            state_d = StData;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      StData: begin
        if (sample) begin
          shreg_d[bit_idx_q] = rxd_s;
          clk_cnt_d          = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = par_en_q ? StParity : StStop;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      StParity: begin
        if (sample) begin
          par_bad_d = rxd_s ^ even_parity(shreg_q);
          clk_cnt_d = '0;
          state_d   = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      StStop: begin
        if (sample) begin
          rx_data_d  = shreg_q;
          stop_err_d = ~rxd_s;
          par_err_d  = par_en_q & par_bad_q;
          valid_d    = 1'b1;
          busy_d     = 1'b0;
          clk_cnt_d  = '0;
          state_d    = StIdle;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      par_en_q   <= 1'b0;
      par_bad_q  <= 1'b0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      par_en_q   <= par_en_d;
      par_bad_q  <= par_bad_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      busy_q     <= busy_d;
    end
  end

  assign RX_DATA    = rx_data_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign stop_err   = stop_err_q;
  assign busy       = busy_q;

endmodule
